fiat_25519_carry_reduce: RTL and testbench

FIAT_25519_CARRY_REDUCE -- requirements
Module: fiat_25519_carry_reduce

---
 rtl/fiat_25519_pkg.sv | 17 +
 rtl/fiat_25519_mul19.sv | 21 ++
 rtl/fiat_25519_carry_reduce.sv | 123 ++++++++++++
 tb/tb_fiat_25519_carry_reduce.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fiat_25519_pkg.sv
// Shared constants and FSM state encoding for the curve25519 carry/reduce tail.
package fiat_25519_pkg;

  localparam int unsigned LIMB_BITS  = 51;
  localparam int unsigned NUM_LIMBS  = 5;
  localparam int unsigned FOLD_CONST = 19;
  localparam logic [LIMB_BITS-1:0] LIMB_MASK = '1;

  typedef enum logic [2:0] {
    IDLE,
    CARRY,
    FOLD,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/fiat_25519_mul19.sv
// Combinational multiply-by-19 as shift-add: 16x + 2x + x.
module fiat_25519_mul19 #(
  parameter int unsigned IN_W  = 78,
  parameter int unsigned OUT_W = IN_W + 5
) (
  input  logic [IN_W-1:0]  i_x,
  output logic [OUT_W-1:0] o_p
);

  logic [OUT_W-1:0] w_x16;
  logic [OUT_W-1:0] w_x2;
  logic [OUT_W-1:0] w_x1;

  always_comb begin
    w_x16 = OUT_W'({i_x, 4'b0000});
    w_x2  = OUT_W'({i_x, 1'b0});
    w_x1  = OUT_W'(i_x);
    o_p   = w_x16 + w_x2 + w_x1;
  end

endmodule

// File: rtl/fiat_25519_carry_reduce.sv
// Serial carry chain over five column accumulators, 2^255 == 19 fold, and one
// final l0->l1 carry, producing loose-form radix-2^51 limbs (fiat carry_mul tail).
module fiat_25519_carry_reduce #(
  parameter int unsigned LIMB_BITS = fiat_25519_pkg::LIMB_BITS,
  parameter int unsigned ACC_WIDTH = 128,
  parameter int unsigned OUT_WIDTH = 64
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5*ACC_WIDTH-1:0] in_acc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5*OUT_WIDTH-1:0] out_limbs
);

  import fiat_25519_pkg::*;

  // One extra sum bit keeps acc_k + c(k-1) exact even for all-ones columns.
  localparam int unsigned SUM_W     = ACC_WIDTH + 1;
  localparam int unsigned CARRY_W   = SUM_W - LIMB_BITS;
  localparam int unsigned FOLD_BITS = $clog2(FOLD_CONST + 1);
  localparam int unsigned PROD_W    = CARRY_W + FOLD_BITS;
  localparam int unsigned FOLD_W    = PROD_W + 1;

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_k;
  logic [ACC_WIDTH-1:0] r_acc  [NUM_LIMBS];
  logic [OUT_WIDTH-1:0] r_limb [NUM_LIMBS];
  logic [CARRY_W-1:0]   r_carry;
  logic [FOLD_W-1:0]    r_fold;
  logic [SUM_W-1:0]     w_sum;
  logic [PROD_W-1:0]    w_prod;

  fiat_25519_mul19 #(
    .IN_W  (CARRY_W),
    .OUT_W (PROD_W)
  ) u_mul19 (
    .i_x (r_carry),
    .o_p (w_prod)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = CARRY;
      end
      CARRY: if (r_k == 3'(NUM_LIMBS - 1)) w_next = FOLD;
      FOLD:  w_next = FIX;
      FIX:   w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_sum = SUM_W'(r_acc[0]) + SUM_W'(r_carry);
  end

  // Accumulators shift down and limbs shift in from the top, so step k always
  // reads r_acc[0] and after five steps limb 0 sits in r_limb[0].
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_k     <= '0;
      r_carry <= '0;
      r_fold  <= '0;
      for (int unsigned i = 0; i < NUM_LIMBS; i++) begin
        r_acc[i]  <= '0;
        r_limb[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_k     <= '0;
            r_carry <= '0;
            for (int unsigned i = 0; i < NUM_LIMBS; i++)
              r_acc[i] <= in_acc[i*ACC_WIDTH +: ACC_WIDTH];
          end
        end
        CARRY: begin
          for (int unsigned i = 0; i < NUM_LIMBS - 1; i++) begin
            r_acc[i]  <= r_acc[i+1];
            r_limb[i] <= r_limb[i+1];
          end
          r_acc[NUM_LIMBS-1]  <= '0;
          r_limb[NUM_LIMBS-1] <= OUT_WIDTH'(w_sum[LIMB_BITS-1:0]);
          r_carry             <= w_sum[SUM_W-1:LIMB_BITS];
          r_k                 <= (r_k == 3'(NUM_LIMBS - 1)) ? '0 : r_k + 3'd1;
        end
        FOLD: begin
          r_fold <= FOLD_W'(r_limb[0]) + FOLD_W'(w_prod);
        end
        FIX: begin
          r_limb[0] <= OUT_WIDTH'(r_fold & FOLD_W'(LIMB_MASK));
          r_limb[1] <= r_limb[1] + OUT_WIDTH'(r_fold[FOLD_W-1:LIMB_BITS]);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_limbs = '0;
    for (int unsigned i = 0; i < NUM_LIMBS; i++)
      out_limbs[i*OUT_WIDTH +: OUT_WIDTH] = r_limb[i];
  end

endmodule

// File: tb/tb_fiat_25519_carry_reduce.sv
// Directed and random checks of fiat_25519_carry_reduce against a big-integer model.
module tb_fiat_25519_carry_reduce;

  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic         in_valid;
  logic         in_ready;
  logic [639:0] in_acc;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] out_limbs;

  int unsigned nerr = 0;
  int unsigned nchk = 0;

  always #5 ap_clk = ~ap_clk;

  fiat_25519_carry_reduce #(
    .LIMB_BITS (51),
    .ACC_WIDTH (128),
    .OUT_WIDTH (64)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_limbs (out_limbs)
  );

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value view: the carry chain is exact addition of N = sum acc_i*2^(51i),
  // so pre-fold limbs are bit fields of N and c4 = N >> 255.
  function automatic logic [319:0] model(input logic [639:0] acc);
    logic [399:0] n;
    logic [399:0] c4;
    logic [399:0] l0w;
    logic [63:0]  l [5];
    n = '0;
    for (int i = 0; i < 5; i++)
      n = n + (400'(acc[i*128 +: 128]) << (51 * i));
    c4  = n >> 255;
    l0w = 400'(n[50:0]) + c4 * 400'd19;
    for (int k = 0; k < 5; k++) l[k] = 64'(n[k*51 +: 51]);
    l[0] = 64'(l0w[50:0]);
    l[1] = l[1] + 64'(l0w >> 51);
    return {l[4], l[3], l[2], l[1], l[0]};
  endfunction

  function automatic logic [127:0] rnd128();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r >> $urandom_range(0, 127);
  endfunction

  function automatic logic [639:0] rnd_set();
    return {rnd128(), rnd128(), rnd128(), rnd128(), rnd128()};
  endfunction

  // Entered and left at a falling edge with the DUT idle.
  task automatic run_set(input logic [639:0] acc, input int unsigned stall,
                         input bit use_exp, input logic [319:0] exp_in, input string tag);
    logic [319:0] exp;
    logic [319:0] held;
    int unsigned  lat;
    exp = use_exp ? exp_in : model(acc);
    chk({tag, ".in_ready"}, 320'(in_ready), 320'(1));
    in_valid  = 1'b1;
    in_acc    = acc;
    out_ready = (stall == 0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_acc = rnd_set();
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      lat++;
      in_acc = rnd_set();
    end
    chk({tag, ".latency"}, 320'(lat), 320'(7));
    chk({tag, ".limbs"}, out_limbs, exp);
    held = out_limbs;
    for (int unsigned s = 0; s < stall; s++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      in_acc = rnd_set();
      chk({tag, ".hold_limbs"}, out_limbs, held);
      chk({tag, ".hold_flags"}, 320'({out_valid, in_ready}), 320'(2'b10));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk({tag, ".release"}, 320'({out_valid, in_ready}), 320'(2'b01));
  endtask

  initial begin
    logic [639:0] v;
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    in_acc    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("reset.flags", 320'({out_valid, in_ready}), 320'(2'b01));
    chk("reset.limbs", out_limbs, 320'(0));

    run_set('0, 0, 1'b1, 320'(0), "zero");

    v = '0;
    v[51] = 1'b1;
    run_set(v, 0, 1'b1, {64'd0, 64'd0, 64'd0, 64'd1, 64'd0}, "acc0_2p51");

    v = '0;
    v[4*128 +: 128] = (128'd1 << 51) + 128'd5;
    run_set(v, 0, 1'b1, {64'd5, 64'd0, 64'd0, 64'd0, 64'd19}, "acc4_2p51p5");

    v = '1;
    run_set(v, 0, 1'b0, '0, "all_ones");

    run_set(rnd_set(), 10, 1'b0, '0, "stall");
    run_set(rnd_set(), 0, 1'b0, '0, "after_stall");

    // Reset lands while the CARRY step with k=2 is in flight.
    in_valid = 1'b1;
    in_acc   = rnd_set();
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    @(posedge ap_clk);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("midreset.flags", 320'({out_valid, in_ready}), 320'(2'b01));
    chk("midreset.limbs", out_limbs, 320'(0));
    run_set(rnd_set(), 0, 1'b0, '0, "post_reset");

    for (int i = 0; i < 1000; i++)
      run_set(rnd_set(), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0,
              1'b0, '0, "random");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
